midori_ti_q_layer: RTL and testbench

- Serialized 3-share threshold implementation of the quadratic stage of the decomposed Midori64 S-box layer.
- Sits directly upstream of the per-nibble shared affine stage.
- Accepts a 64-bit state as three Boolean shares and applies the quadratic map Q to all 16 nibbles, NPC nibbles per cycle.
- Result shares are registered; the state register acts as the glitch barrier before the affine stage. No fresh randomness is used.

---
 rtl/midori_ti_q_layer.sv | 104 ++++++++++
 tb/tb_midori_ti_q_layer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/midori_ti_q_layer.sv
// Serialized 3-share threshold implementation of the Midori64 quadratic S-box stage.
// NPC nibbles per share are transformed and rotated each RUN cycle; registers form the glitch barrier.
module midori_ti_q_layer #(
   parameter int NPC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] s0_in,
   input  logic [63:0] s1_in,
   input  logic [63:0] s2_in,
   output logic        busy,
   output logic        done,
   output logic [63:0] s0_out,
   output logic [63:0] s1_out,
   output logic [63:0] s2_out
);

   localparam int NRUN = 16 / NPC;
   localparam int CW   = (NRUN > 1) ? $clog2(NRUN) : 1;
   localparam int SW   = 4 * NPC;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t              state_reg, state_next;
   logic [CW-1:0]       count_reg, count_next;
   logic [2:0][63:0]    sh_reg, sh_next;
   logic [2:0][63:0]    rot;

   // Output share i of Q from input shares j and k only; share i never enters its own output.
   function automatic logic [3:0] q_share(input logic [3:0] xj, input logic [3:0] xk);
      logic [3:0] q;
      q[3] = xj[3];
      q[2] = xj[2];
      q[1] = xj[1] ^ (xj[3] & xj[2]) ^ (xj[3] & xk[2]) ^ (xk[3] & xj[2]);
      q[0] = xj[0] ^ (xj[2] & xj[1]) ^ (xj[2] & xk[1]) ^ (xk[2] & xj[1]);
      return q;
   endfunction

   genvar gi, gn;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_share
         logic [SW-1:0] low_q;
         for (gn = 0; gn < NPC; gn++) begin : g_nib
            assign low_q[4*gn +: 4] = q_share(sh_reg[(gi+1)%3][4*gn +: 4],
                                              sh_reg[(gi+2)%3][4*gn +: 4]);
         end
         // Transformed nibbles re-enter at the top so NRUN rotations restore nibble order.
         if (NPC == 16) begin : g_full
            assign rot[gi] = low_q;
         end else begin : g_part
            assign rot[gi] = {low_q, sh_reg[gi][63:SW]};
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         sh_reg    <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         sh_reg    <= sh_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      sh_next    = sh_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               sh_next    = {s2_in, s1_in, s0_in};
               count_next = '0;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            sh_next = rot;
            if (count_reg == CW'(NRUN - 1)) begin
               state_next = ST_DONE;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign busy   = (state_reg != ST_IDLE);
   assign done   = (state_reg == ST_DONE);
   assign s0_out = sh_reg[0];
   assign s1_out = sh_reg[1];
   assign s2_out = sh_reg[2];

endmodule

// File: tb/tb_midori_ti_q_layer.sv
// Scoreboard bench for midori_ti_q_layer: five instances (NPC = 1,2,4,8,16) checked against
// a word-level reference of Q and of its 3-share non-complete sharing.
module tb_midori_ti_q_layer;

   localparam logic [63:0] M = 64'h1111_1111_1111_1111;

   typedef struct {
      logic [63:0] r;
      logic [63:0] e0;
      logic [63:0] e1;
      logic [63:0] e2;
      int          start_cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [4:0]  start_v;
   logic [63:0] a0, a1, a2;
   logic [4:0]  busy_v, done_v;
   logic [63:0] o0 [5];
   logic [63:0] o1 [5];
   logic [63:0] o2 [5];

   exp_t exp_q [5][$];
   int   done_cnt [5];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Unshared Q over all 16 nibbles at once: q1 ^= x3&x2, q0 ^= x2&x1.
   function automatic logic [63:0] q_ref(input logic [63:0] w);
      logic [63:0] x3, x2, x1;
      x3 = (w >> 3) & M;
      x2 = (w >> 2) & M;
      x1 = (w >> 1) & M;
      return w ^ ((x3 & x2) << 1) ^ (x2 & x1);
   endfunction

   // Shared product a&b from shares j,k written as (aj^ak)&(bj^bk) ^ ak&bk.
   function automatic logic [63:0] sh_ref(input logic [63:0] wj, input logic [63:0] wk);
      logic [63:0] p32, p21;
      p32 = ((((wj >> 3) ^ (wk >> 3)) & ((wj >> 2) ^ (wk >> 2))) ^ ((wk >> 3) & (wk >> 2))) & M;
      p21 = ((((wj >> 2) ^ (wk >> 2)) & ((wj >> 1) ^ (wk >> 1))) ^ ((wk >> 2) & (wk >> 1))) & M;
      return wj ^ (p32 << 1) ^ p21;
   endfunction

   task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s npc=%0d got %h required %h", name, 1 << inst, act, req);
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_dut
         midori_ti_q_layer #(.NPC(1 << gi)) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start_v[gi]),
            .s0_in  (a0),
            .s1_in  (a1),
            .s2_in  (a2),
            .busy   (busy_v[gi]),
            .done   (done_v[gi]),
            .s0_out (o0[gi]),
            .s1_out (o1[gi]),
            .s2_out (o2[gi])
         );

         always @(posedge clk) begin : mon
            exp_t e;
            #1;
            if (done_v[gi]) begin
               done_cnt[gi]++;
               checks++;
               if (exp_q[gi].size() == 0) begin
                  $display("FAIL done_without_request npc=%0d got done=1 required no pending op", 1 << gi);
               end else begin
                  passes++;
                  e = exp_q[gi].pop_front();
                  chk("recombined", gi, o0[gi] ^ o1[gi] ^ o2[gi], e.r);
                  chk("share0", gi, o0[gi], e.e0);
                  chk("share1", gi, o1[gi], e.e1);
                  chk("share2", gi, o2[gi], e.e2);
                  chk("latency", gi, 64'(cyc - e.start_cyc), 64'(16 >> gi));
                  $display("op npc=%0d in=%h out=%h lat=%0d", 1 << gi, e.r, o0[gi] ^ o1[gi] ^ o2[gi],
                           cyc - e.start_cyc);
               end
            end
         end
      end
   endgenerate

   function automatic exp_t make_exp(input logic [63:0] x0, input logic [63:0] x1, input logic [63:0] x2);
      exp_t e;
      e.r  = q_ref(x0 ^ x1 ^ x2);
      e.e0 = sh_ref(x1, x2);
      e.e1 = sh_ref(x2, x0);
      e.e2 = sh_ref(x0, x1);
      e.start_cyc = 0;
      return e;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic check_zero();
      for (int i = 0; i < 5; i++) begin
         chk("rst_s0", i, o0[i], 64'd0);
         chk("rst_s1", i, o1[i], 64'd0);
         chk("rst_s2", i, o2[i], 64'd0);
         chk("rst_busy", i, 64'(busy_v[i]), 64'd0);
         chk("rst_done", i, 64'(done_v[i]), 64'd0);
      end
   endtask

   // Waits for the selected instances to be idle, then issues one start with the given shares.
   task automatic run_op(input logic [63:0] x0, input logic [63:0] x1, input logic [63:0] x2,
                         input logic [4:0] mask);
      exp_t e;
      int n;
      n = 0;
      @(negedge clk);
      while (((busy_v & mask) != 5'd0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 0, 64'(busy_v & mask), 64'd0);
      a0 = x0;
      a1 = x1;
      a2 = x2;
      start_v = mask;
      e = make_exp(x0, x1, x2);
      e.start_cyc = cyc + 1;
      for (int i = 0; i < 5; i++) if (mask[i]) exp_q[i].push_back(e);
      @(negedge clk);
      start_v = 5'd0;
   endtask

   task automatic run_shared(input logic [63:0] x);
      logic [63:0] m0, m1;
      m0 = rnd64();
      m1 = rnd64();
      run_op(m0, m1, x ^ m0 ^ m1, 5'h1f);
   endtask

   function automatic int pending();
      int p;
      p = 0;
      for (int i = 0; i < 5; i++) p += exp_q[i].size();
      return p;
   endfunction

   initial begin : drive
      int bc, d0, n;
      rst = 1'b1;
      start_v = 5'd0;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      for (int i = 0; i < 5; i++) done_cnt[i] = 0;
      #3;
      check_zero();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset asserted mid-cycle during the second RUN cycle discards the operation.
      run_op(rnd64(), rnd64(), rnd64(), 5'h1f);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_zero();
      for (int i = 0; i < 5; i++) exp_q[i].delete();
      @(negedge clk);
      rst = 1'b0;

      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 5'h1f);
      run_shared(64'h6666_6666_6666_6666);
      run_shared(64'hEEEE_EEEE_EEEE_EEEE);
      run_shared(64'd0);

      // start held across the whole operation on the NPC=4 instance: one op, busy for 5 cycles.
      n = 0;
      @(negedge clk);
      while (busy_v != 5'd0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      d0 = done_cnt[2];
      bc = 0;
      a0 = rnd64();
      a1 = rnd64();
      a2 = rnd64();
      start_v = 5'b00100;
      exp_q[2].push_back(make_exp(a0, a1, a2));
      exp_q[2][exp_q[2].size()-1].start_cyc = cyc + 1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (busy_v[2]) bc++;
         @(negedge clk);
         if (k == 5) start_v = 5'd0;
         a0 = rnd64();
         a1 = rnd64();
         a2 = rnd64();
      end
      chk("busy_cycles", 2, 64'(bc), 64'd5);
      chk("done_pulses", 2, 64'(done_cnt[2] - d0), 64'd1);

      for (int t = 0; t < 1000; t++) run_op(rnd64(), rnd64(), rnd64(), 5'h1f);

      n = 0;
      while (pending() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 0, 64'(pending()), 64'd0);
      #20;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
